// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit bus slave driving a 16-bit asynchronous SRAM.
// Each request becomes one or two halfword accesses (high half first).
// Defining SRAM_CTRL_RDBUF_EN adds a one-entry buffer for full-word reads.
// All SRAM pins are registered, so strobes are glitch-free and reset to idle.
module sram_ctrl #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic [3:0]         byteenable,
    output logic [31:0]        readdata,
    output logic               waitrequest,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int         WW       = SRAM_AW - 1;
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WW-1:0]      word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               wr_q, wr_d;
    logic               half_q, half_d;
    logic [31:0]        readdata_q, readdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;
    logic               lo_half;
`ifdef SRAM_CTRL_RDBUF_EN
    logic               buf_valid_q, buf_valid_d;
    logic [WW-1:0]      buf_word_q, buf_word_d;
    logic [31:0]        buf_data_q, buf_data_d;
`endif

    // Address bits outside the SRAM window are decoded upstream.
    logic unused_addr;
    assign unused_addr = ^{address[31:SRAM_AW+1], address[1:0]};

    assign waitrequest = (read | write) & (state_q != DONE);
    assign readdata    = readdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

    // Sequencer: request capture, per-half strobe timing and read data capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        half_d     = half_q;
        readdata_d = readdata_q;
`ifdef SRAM_CTRL_RDBUF_EN
        buf_valid_d = buf_valid_q;
        buf_word_d  = buf_word_q;
        buf_data_d  = buf_data_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (read | write) begin
                    word_d  = address[SRAM_AW:2];
                    wdata_d = writedata;
                    be_d    = byteenable;
                    wr_d    = write;
                    cnt_d   = 4'd0;
                    if (!write) begin
                        readdata_d = 32'd0;
                    end
`ifdef SRAM_CTRL_RDBUF_EN
                    if (write && (address[SRAM_AW:2] == buf_word_q)) begin
                        buf_valid_d = 1'b0;
                    end
`endif
                    if (byteenable == 4'b0000) begin
                        state_d = DONE;
                    end
`ifdef SRAM_CTRL_RDBUF_EN
                    else if (!write && (byteenable == 4'b1111) && buf_valid_q &&
                             (address[SRAM_AW:2] == buf_word_q)) begin
                        state_d    = DONE;
                        readdata_d = buf_data_q;
                    end
`endif
                    else if (write) begin
                        state_d = WR_SETUP;
                        half_d  = (byteenable[3:2] == 2'b00);
                    end else begin
                        state_d = (byteenable[3:2] != 2'b00) ? RD_HI : RD_LO;
                    end
                end
            end
            RD_HI: begin
                if (cnt_q == CNT_LAST) begin
                    readdata_d[31:16] = sram_dq_in;
                    cnt_d             = 4'd0;
                    state_d           = (be_q[1:0] != 2'b00) ? RD_LO : DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_LO: begin
                if (cnt_q == CNT_LAST) begin
                    readdata_d[15:0] = sram_dq_in;
                    cnt_d            = 4'd0;
                    state_d          = DONE;
`ifdef SRAM_CTRL_RDBUF_EN
                    if (be_q == 4'b1111) begin
                        buf_valid_d = 1'b1;
                        buf_word_d  = word_q;
                        buf_data_d  = {readdata_q[31:16], sram_dq_in};
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_SETUP: begin
                cnt_d   = 4'd0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_HOLD: begin
                if (!half_q && (be_q[1:0] != 2'b00)) begin
                    half_d  = 1'b1;
                    state_d = WR_SETUP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pin values for the coming cycle, derived from the next state so they register cleanly.
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        lo_half  = half_d;
        unique case (state_d)
            RD_HI, RD_LO: begin
                lo_half = (state_d == RD_LO);
                ce_n_d  = 1'b0;
                oe_n_d  = 1'b0;
                addr_d  = {word_d, lo_half};
                ub_n_d  = lo_half ? ~be_d[1] : ~be_d[3];
                lb_n_d  = lo_half ? ~be_d[0] : ~be_d[2];
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                ce_n_d   = 1'b0;
                dq_oe_d  = 1'b1;
                we_n_d   = (state_d != WR_PULSE);
                addr_d   = {word_d, lo_half};
                dq_out_d = lo_half ? wdata_d[15:0] : wdata_d[31:16];
                ub_n_d   = lo_half ? ~be_d[1] : ~be_d[3];
                lb_n_d   = lo_half ? ~be_d[0] : ~be_d[2];
            end
            default: begin
            end
        endcase
    end

    // State and pin registers; reset forces the SRAM idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            word_q     <= '0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            wr_q       <= 1'b0;
            half_q     <= 1'b0;
            readdata_q <= 32'd0;
            addr_q     <= '0;
            dq_out_q   <= 16'd0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
`ifdef SRAM_CTRL_RDBUF_EN
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            half_q     <= half_d;
            readdata_q <= readdata_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
`ifdef SRAM_CTRL_RDBUF_EN
            buf_valid_q <= buf_valid_d;
            buf_word_q  <= buf_word_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: word-level reference memory plus a cycle-sampled SRAM device model.
module tb_sram_ctrl;

    localparam int AW = 18;
    localparam int WC = 1;

    logic          clk;
    logic          reset;
    logic [31:0]   address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;

    sram_ctrl #(.SRAM_AW(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .waitrequest(waitrequest), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM device contents (halfwords) and the word-level expected memory.
    logic [15:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:511];
    logic [31:0] last_rd;
    logic        buf_v;
    logic [8:0]  buf_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Device read path: drives stored data while selected and output-enabled.
    always_comb begin
        sram_dq_in = 16'hDEAD;
        if (!sram_ce_n && !sram_oe_n && (sram_addr < 18'd1024)) begin
            sram_dq_in = sram_mem[sram_addr[9:0]];
        end
    end

    // Per-cycle bus monitor: counts strobe cycles and commits writes when we_n rises.
    int          ce_cycles = 0, oe_cycles = 0, we_cycles = 0, we_pulses = 0;
    logic [17:0] last_rd_addr, wr_addr;
    logic        last_rd_ub, last_rd_lb, wr_ub, wr_lb, wr_oe;
    logic [15:0] wr_data;
    logic        pend = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!sram_ce_n) ce_cycles++;
        if (!sram_ce_n && !sram_oe_n) begin
            oe_cycles++;
            last_rd_addr = sram_addr;
            last_rd_ub   = sram_ub_n;
            last_rd_lb   = sram_lb_n;
        end
        if (!sram_ce_n && !sram_we_n) begin
            we_cycles++;
            if (!pend) we_pulses++;
            pend    = 1'b1;
            wr_addr = sram_addr;
            wr_data = sram_dq_out;
            wr_ub   = sram_ub_n;
            wr_lb   = sram_lb_n;
            wr_oe   = sram_dq_oe;
        end else if (pend) begin
            pend = 1'b0;
            if (wr_oe && (wr_addr < 18'd1024)) begin
                if (!wr_ub) sram_mem[wr_addr[9:0]][15:8] = wr_data[15:8];
                if (!wr_lb) sram_mem[wr_addr[9:0]][7:0]  = wr_data[7:0];
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int halves(input logic [3:0] be);
        return int'(be[3:2] != 2'b00) + int'(be[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] masked(input logic [31:0] w, input logic [3:0] be);
        return {(be[3:2] != 2'b00) ? w[31:16] : 16'h0000, (be[1:0] != 2'b00) ? w[15:0] : 16'h0000};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Issue one bus request and wait (bounded) for waitrequest to drop.
    int s_ce, s_oe, s_we, s_pulses;
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wd,
                                  output int lat, output logic [31:0] rdata);
        @(negedge clk);
        address = addr; read = rd; write = wr; byteenable = be; writedata = wd;
        s_ce = ce_cycles; s_oe = oe_cycles; s_we = we_cycles; s_pulses = we_pulses;
        lat = 0;
        #1;
        while (waitrequest && lat < 200) begin
            lat++;
            @(negedge clk);
            #1;
        end
        rdata = readdata;
        read = 1'b0; write = 1'b0;
    endtask

    // Run a request and compare timing, strobes and data against the reference model.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        int          lat, n, exp_lat;
        logic [31:0] rdata, exp_rd;
        logic [8:0]  w;
        logic        hit;
        w   = addr[10:2];
        n   = halves(be);
        hit = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
        hit = !wr && (be == 4'hF) && buf_v && (buf_w == w);
        if (wr && (buf_w == w)) buf_v = 1'b0;
`endif
        if (wr) begin
            exp_lat = 1 + n * (WC + 3);
            exp_rd  = last_rd;
        end else begin
            exp_lat = hit ? 1 : 1 + n * (WC + 1);
            exp_rd  = masked(ref_mem[w], be);
        end
        apply_stimulus(rd, wr, addr, be, wd, lat, rdata);
        check_output({tag, " latency"}, lat, exp_lat);
        check_output({tag, " readdata"}, rdata, exp_rd);
        check_output({tag, " oe_cycles"}, oe_cycles - s_oe, (wr || hit) ? 0 : n * (WC + 1));
        check_output({tag, " we_cycles"}, we_cycles - s_we, wr ? n * (WC + 1) : 0);
        check_output({tag, " we_pulses"}, we_pulses - s_pulses, wr ? n : 0);
        if (wr) begin
            ref_mem[w] = merge(ref_mem[w], wd, be);
        end else begin
            last_rd = exp_rd;
`ifdef SRAM_CTRL_RDBUF_EN
            if (be == 4'hF) begin
                buf_v = 1'b1;
                buf_w = w;
            end
`endif
        end
    endtask

    initial begin
        logic [15:0] keep23;
        logic [31:0] a, d;
        logic [3:0]  be;
        int          kind, guard;

        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = 32'd0; writedata = 32'd0; byteenable = 4'd0;
        last_rd = 32'd0; buf_v = 1'b0; buf_w = 9'd0;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i]         = $urandom;
            sram_mem[2*i]      = ref_mem[i][31:16];
            sram_mem[2*i + 1]  = ref_mem[i][15:0];
        end
        ref_mem[9'h010] = 32'h12345678;
        sram_mem[10'h020] = 16'h1234;
        sram_mem[10'h021] = 16'h5678;

        // Reset values while reset is held.
        #12;
        check_output("rst readdata", readdata, 32'd0);
        check_output("rst waitrequest", {31'd0, waitrequest}, 32'd0);
        check_output("rst sram_addr", {14'd0, sram_addr}, 32'd0);
        check_output("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
        check_output("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check_output("rst strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed transactions");
        run_txn("rd40", 1'b1, 1'b0, 32'h40, 4'b1111, 32'd0);
        keep23 = sram_mem[10'h023];
        run_txn("wr44", 1'b0, 1'b1, 32'h44, 4'b1100, 32'hABCD0000);
        check_output("wr44 addr", {14'd0, wr_addr}, 32'h22);
        check_output("wr44 data", {16'd0, wr_data}, 32'hABCD);
        check_output("wr44 ublb", {30'd0, wr_ub, wr_lb}, 32'd0);
        check_output("wr44 mem22", {16'd0, sram_mem[10'h022]}, 32'hABCD);
        check_output("wr44 mem23", {16'd0, sram_mem[10'h023]}, {16'd0, keep23});
        run_txn("rd40be1", 1'b1, 1'b0, 32'h40, 4'b0001, 32'd0);
        check_output("rd40be1 addr", {14'd0, last_rd_addr}, 32'h21);
        check_output("rd40be1 ublb", {30'd0, last_rd_ub, last_rd_lb}, 32'h2);
        check_output("rd40be1 data", readdata, 32'h00005678);
        run_txn("be0", 1'b1, 1'b0, 32'h48, 4'b0000, 32'd0);
        check_output("be0 ce_cycles", ce_cycles - s_ce, 32'd0);
        run_txn("rdwr", 1'b1, 1'b1, 32'h4C, 4'b1111, 32'hCAFEF00D);
        check_output("rdwr mem", {sram_mem[10'h026], sram_mem[10'h027]}, 32'hCAFEF00D);

`ifdef SRAM_CTRL_RDBUF_EN
        $display("[TB] read buffer");
        run_txn("buf rd1", 1'b1, 1'b0, 32'h40, 4'b1111, 32'd0);
        run_txn("buf rd2", 1'b1, 1'b0, 32'h40, 4'b1111, 32'd0);
        run_txn("buf wr", 1'b0, 1'b1, 32'h40, 4'b1111, 32'h0BADBEEF);
        run_txn("buf rd3", 1'b1, 1'b0, 32'h40, 4'b1111, 32'd0);
        check_output("buf rd3 data", readdata, 32'h0BADBEEF);
`endif

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            be   = 4'($urandom);
            a    = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            d    = $urandom;
            run_txn("rand", (kind != 2), (kind >= 2), a, be, d);
        end

        $display("[TB] request dropped mid-transaction");
        @(negedge clk);
        s_oe = oe_cycles;
        address = 32'h40; byteenable = 4'b1111; read = 1'b1;
        repeat (2) @(negedge clk);
        read = 1'b0;
        repeat (10) @(negedge clk);
        check_output("drop readdata", readdata, ref_mem[9'h010]);
        check_output("drop oe_cycles", oe_cycles - s_oe, 2 * (WC + 1));
        last_rd = ref_mem[9'h010];
        buf_v = 1'b1; buf_w = 9'h010;

        $display("[TB] reset during write pulse");
        @(negedge clk);
        address = 32'h600; byteenable = 4'b1111; writedata = 32'h13572468; write = 1'b1;
        guard = 0;
        while (sram_we_n && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_output("rst pulse reached", {31'd0, sram_we_n}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check_output("rst async we_n", {31'd0, sram_we_n}, 32'd1);
        check_output("rst async ce_n", {31'd0, sram_ce_n}, 32'd1);
        check_output("rst async dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        check_output("rst async readdata", readdata, 32'd0);
        write = 1'b0;
        last_rd = 32'd0; buf_v = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_txn("post rst rd", 1'b1, 1'b0, 32'h40, 4'b1111, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Bus slave sitting directly downstream of the CPU memory port.
- Accepts 32-bit read/write requests with byte enables and waitrequest handshake.
- Converts each request into one or two 16-bit accesses on an external asynchronous SRAM.
- Returns raw 32-bit lane data; sign extension and lane selection are done by the master.

Parameters:
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 1: extra strobe cycles per SRAM access. Legal range 0..15; held in a 4-bit counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- address  in  32  byte address; bits [SRAM_AW:2] used, rest ignored (decoded upstream)
- read  in  1  read request
- write  in  1  write request; wins if read also asserted
- writedata  in  32  write data, already lane-aligned by master
- byteenable  in  4  lane enables; [3:2] = high halfword, [1:0] = low halfword
- readdata  out  32  read data, valid in the cycle waitrequest drops
- waitrequest  out  1  master must hold request while high
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_out  out  16  data to SRAM
- sram_dq_in  in  16  data from SRAM
- sram_dq_oe  out  1  tristate enable for sram_dq_out
- sram_ce_n  out  1  chip enable
- sram_oe_n  out  1  output enable
- sram_we_n  out  1  write enable
- sram_ub_n  out  1  upper byte enable
- sram_lb_n  out  1  lower byte enable

Behaviour:
- Reset values (asynchronous, immediate, including mid-access):
  - readdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n all 1.
  - State IDLE, counter 0.
- Address and lane mapping (big-endian):
  - High halfword (readdata/writedata[31:16], be[3:2]) is at sram_addr={address[SRAM_AW:2],0}.
  - Low halfword ([15:0], be[1:0]) is at sram_addr={address[SRAM_AW:2],1}.
  - Within a halfword: ub_n=~be[3] or ~be[1]; lb_n=~be[2] or ~be[0].
- waitrequest = (read|write) & (state!=DONE), combinational.
- State machine: IDLE, RD_HI, RD_LO, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - On a request, latch address, writedata, byteenable and direction.
  - Go to the first enabled half: HI before LO.
  - If byteenable=0000, go straight to DONE with no SRAM activity.
- RD_x:
  - Hold ce_n=0, oe_n=0, dq_oe=0 for WAIT_CYCLES+1 cycles.
  - On the last cycle, register sram_dq_in into that half of readdata.
  - Then go to the next enabled half, else DONE.
- Write, per enabled half:
  - WR_SETUP (1 cycle): ce_n=0, we_n=1, dq_oe=1, data driven.
  - WR_PULSE (WAIT_CYCLES+1 cycles): we_n=0.
  - WR_HOLD (1 cycle): we_n=1, data still driven.
  - Then the next half, else DONE.
- Address and data are stable throughout each half-access. ce_n returns to 1 between halves only in IDLE/DONE.
- DONE:
  - Exactly one cycle, waitrequest=0. readdata holds the new word.
  - Any half not accessed reads as 0.
  - Then IDLE. A new request is first sampled in IDLE, with no back-to-back issue from DONE.
- Latency: waitrequest-high cycles before the drop.
  - Read = 1 + n*(WAIT_CYCLES+1).
  - Write = 1 + n*(WAIT_CYCLES+3).
  - n = number of enabled halves (0..2).
- readdata holds its value between transactions. Writes do not modify it.
- Master deasserting the request mid-transaction (protocol violation): the SRAM sequence still completes and DONE still occurs; no partial strobes.

Optional Feature:
- Macro: SRAM_CTRL_RDBUF_EN.
- With the macro defined:
  - A one-entry read buffer holds the word address of the last completed byteenable=1111 read, plus a valid bit.
  - Buffer hit: a later 1111 read to the same word while valid goes IDLE->DONE with no SRAM cycles (waitrequest high 1 cycle) and returns buffered data.
  - Any write to that word clears valid. Reset clears valid.
- Without the macro: no buffer; every read accesses the SRAM.

Test Plan:
- WAIT_CYCLES=1, SRAM[0x20]=0x1234, SRAM[0x21]=0x5678; read address=0x40, be=1111 -> waitrequest high 5 cycles, readdata=0x12345678 in the 6th; oe_n low 4 cycles.
- Write address=0x44, be=1100, writedata=0xABCD0000 -> single we_n pulse of 2 cycles at sram_addr=0x22 with dq=0xABCD, ub_n=lb_n=0; waitrequest high 5 cycles; SRAM[0x23] unchanged.
- Read be=0001 at 0x40 -> only sram_addr=0x21 accessed with ub_n=1, lb_n=0; readdata=0x00005678 (high half 0).
- Request with be=0000 -> waitrequest high 1 cycle, no ce_n activity; read and write both asserted -> write sequence performed.
- Assert reset during WR_PULSE -> we_n, ce_n go 1 and dq_oe goes 0 asynchronously; after release, a new read completes normally.
- SRAM_CTRL_RDBUF_EN: read 0x40 twice -> second read has waitrequest high 1 cycle, no SRAM cycles; write 0x40 then read -> full SRAM read (5 cycles) with new data.
